// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks register indices FIRST..LAST through one spare read port of the CPU
//   register file. Each word is captured and presented as an (index, data) beat
//   over a valid/ready handshake to a debug/display consumer. Read-only.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a dump (only looked at in IDLE)
//   abort      cancel a dump in progress (READ/SEND), wins over start/handshake
//   rd_addr    registered index driven to the register-file read port
//   rd_data    combinational read data for rd_addr
//   out_valid  beat valid
//   out_ready  consumer accepts when out_valid & out_ready
//   out_idx    index of the presented word
//   out_data   presented word
//   busy       high in READ or SEND
//   done       single-cycle pulse after the last beat is accepted
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FIRST  = 0,
  parameter int LAST   = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t state;

  // rd_addr doubles as the walk index: it is only advanced together with the
  // index, so a separate counter would always hold the same value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            rd_addr <= FIRST_IDX;
            busy    <= 1'b1;
          end
        end

        // Read port has had the whole cycle to settle on rd_addr.
        READ: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            out_data  <= rd_data;
            out_idx   <= rd_addr;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before incrementing so LAST = 2**ADDR_W-1 never wraps.
            if (rd_addr == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              state   <= READ;
            end
          end
        end

        // done is high for exactly this cycle; start/abort are ignored here.
        DONE: state <= IDLE;

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  // instance A: full 0..31 dump
  logic        start_a, abort_a, ready_a;
  logic [4:0]  rd_addr_a, idx_a;
  logic [31:0] rd_data_a, data_a;
  logic        valid_a, busy_a, done_a;
  // instance B: FIRST=3, LAST=5
  logic        start_b, abort_b, ready_b;
  logic [4:0]  rd_addr_b, idx_b;
  logic [31:0] rd_data_b, data_b;
  logic        valid_b, busy_b, done_b;

  logic [31:0] regs [32];   // register file seen by both read ports
  logic [31:0] gold [32];   // expected contents at capture time

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  regfile_dump_reader u_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_idx(idx_a), .out_data(data_a),
    .busy(busy_a), .done(done_a));

  regfile_dump_reader #(.FIRST(3), .LAST(5)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_idx(idx_b), .out_data(data_b),
    .busy(busy_b), .done(done_b));

  typedef struct {
    logic       start, abort, rdy;
    logic       exp_valid, exp_busy, exp_done;
    logic [4:0] exp_idx;
  } vec_t;

  vec_t vec [13];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input int i, input logic [31:0] v);
    regs[i] = v;
    gold[i] = v;
  endtask

  // Full dump on instance A with random out_ready (ready_pct %). Every accepted
  // beat must be the next index in FIRST..LAST order carrying the word present
  // at capture; a stalled beat must not change. Returns the cycle of done,
  // counting the cycle after the start-sampling edge as cycle 1.
  task automatic run_dump(input int ready_pct, input bit do_wr, output int done_cycle);
    int exp_i = 0;
    int cycle;
    bit prev_stall = 0, w10 = 0, pend4 = 0, got_done = 0;
    logic [4:0]  p_idx = '0;
    logic [31:0] p_data = '0;
    done_cycle = -1;
    start_a = 1'b1; abort_a = 1'b0; ready_a = 1'b0;
    tick;
    start_a = 1'b0;
    cycle = 1;
    while (cycle < 1000 && !got_done) begin
      ready_a = ($urandom_range(99) < ready_pct);
      if (prev_stall) begin
        chk("stall_valid", {63'd0, valid_a}, 64'd1);
        chk("stall_idx", {59'd0, idx_a}, {59'd0, p_idx});
        chk("stall_data", {32'd0, data_a}, {32'd0, p_data});
      end
      if (do_wr && pend4) begin
        @(negedge clk); wr(4, 32'h0BAD_F00D); pend4 = 0;
      end
      if (do_wr && !w10 && busy_a && !valid_a && rd_addr_a == 5'd10) begin
        @(negedge clk); wr(10, 32'hDEAD_BEEF); w10 = 1;
      end
      if (valid_a && ready_a) begin
        chk("beat_idx", {59'd0, idx_a}, 64'(exp_i));
        chk("beat_data", {32'd0, data_a}, {32'd0, gold[exp_i % 32]});
        if (exp_i == 4) pend4 = 1;
        exp_i++;
      end
      prev_stall = valid_a && !ready_a;
      p_idx = idx_a; p_data = data_a;
      tick;
      cycle++;
      if (done_a) begin
        got_done = 1;
        done_cycle = cycle;
        chk("done_after_last", 64'(exp_i), 64'd32);
      end
    end
    chk("dump_finished", {63'd0, got_done}, 64'd1);
    chk("beat_count", 64'(exp_i), 64'd32);
    if (do_wr) chk("wr10_hit", {63'd0, w10}, 64'd1);
    ready_a = 1'b0;
    tick;
    chk("done_one_cycle", {63'd0, done_a}, 64'd0);
    chk("idle_after_done", {63'd0, busy_a}, 64'd0);
  endtask

  initial begin
    int dc;
    bit hit;
    for (int i = 0; i < 32; i++) begin
      regs[i] = i * 32'h1111_1111;
      gold[i] = regs[i];
    end
    reset = 1'b1;
    start_a = 0; abort_a = 0; ready_a = 0;
    start_b = 0; abort_b = 0; ready_b = 0;
    tick; tick;

    // reset state
    chk("rst_rd_addr", {59'd0, rd_addr_a}, 64'd0);
    chk("rst_idx", {59'd0, idx_a}, 64'd0);
    chk("rst_data", {32'd0, data_a}, 64'd0);
    chk("rst_valid", {63'd0, valid_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_b_busy", {63'd0, busy_b}, 64'd0);
    reset = 1'b0;
    tick;

    // FIRST=3/LAST=5 walk with start held high, then stall and abort
    vec[0]  = '{1, 0, 1, 0, 1, 0, 5'd0};
    vec[1]  = '{1, 0, 1, 1, 1, 0, 5'd3};
    vec[2]  = '{1, 0, 1, 0, 1, 0, 5'd3};
    vec[3]  = '{1, 0, 1, 1, 1, 0, 5'd4};
    vec[4]  = '{1, 0, 1, 0, 1, 0, 5'd4};
    vec[5]  = '{1, 0, 1, 1, 1, 0, 5'd5};
    vec[6]  = '{1, 0, 1, 0, 0, 1, 5'd5};
    vec[7]  = '{1, 0, 1, 0, 0, 0, 5'd5};
    vec[8]  = '{1, 0, 1, 0, 1, 0, 5'd5};
    vec[9]  = '{0, 0, 0, 1, 1, 0, 5'd3};
    vec[10] = '{0, 0, 0, 1, 1, 0, 5'd3};
    vec[11] = '{1, 1, 1, 0, 0, 0, 5'd3};
    vec[12] = '{0, 0, 1, 0, 0, 0, 5'd3};
    for (int v = 0; v < 13; v++) begin
      start_b = vec[v].start; abort_b = vec[v].abort; ready_b = vec[v].rdy;
      tick;
      chk($sformatf("tbl%0d_valid", v), {63'd0, valid_b}, {63'd0, vec[v].exp_valid});
      chk($sformatf("tbl%0d_busy", v), {63'd0, busy_b}, {63'd0, vec[v].exp_busy});
      chk($sformatf("tbl%0d_done", v), {63'd0, done_b}, {63'd0, vec[v].exp_done});
      chk($sformatf("tbl%0d_idx", v), {59'd0, idx_b}, {59'd0, vec[v].exp_idx});
      if (vec[v].exp_valid)
        chk($sformatf("tbl%0d_data", v), {32'd0, data_b}, {32'd0, gold[vec[v].exp_idx]});
    end
    start_b = 0; abort_b = 0; ready_b = 0;

    // full dump at full rate: done on cycle 65
    run_dump(100, 0, dc);
    chk("done_cycle", 64'(dc), 64'd65);

    // random backpressure
    run_dump(45, 0, dc);

    // abort during SEND idx 7 with a same-cycle handshake
    start_a = 1'b1; ready_a = 1'b1;
    tick;
    start_a = 1'b0;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (valid_a && idx_a == 5'd7) hit = 1;
      else tick;
    end
    chk("abort_reach_7", {63'd0, hit}, 64'd1);
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0; ready_a = 1'b0;
    chk("abort_valid", {63'd0, valid_a}, 64'd0);
    chk("abort_busy", {63'd0, busy_a}, 64'd0);
    chk("abort_done", {63'd0, done_a}, 64'd0);
    chk("abort_idx_hold", {59'd0, idx_a}, 64'd7);
    chk("abort_addr_hold", {59'd0, rd_addr_a}, 64'd7);
    tick;
    chk("abort_no_done", {63'd0, done_a}, 64'd0);
    run_dump(100, 0, dc);

    // falling-edge writes during the dump
    run_dump(70, 1, dc);

    // reset mid-dump at SEND idx 20
    start_a = 1'b1; ready_a = 1'b1;
    tick;
    start_a = 1'b0;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (valid_a && idx_a == 5'd20) hit = 1;
      else tick;
    end
    chk("rst_reach_20", {63'd0, hit}, 64'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0; ready_a = 1'b0;
    chk("mrst_rd_addr", {59'd0, rd_addr_a}, 64'd0);
    chk("mrst_idx", {59'd0, idx_a}, 64'd0);
    chk("mrst_data", {32'd0, data_a}, 64'd0);
    chk("mrst_valid", {63'd0, valid_a}, 64'd0);
    chk("mrst_busy", {63'd0, busy_a}, 64'd0);
    chk("mrst_done", {63'd0, done_a}, 64'd0);
    tick;
    chk("mrst_idle", {63'd0, busy_a}, 64'd0);
    run_dump(100, 0, dc);
    chk("done_cycle_2", 64'(dc), 64'd65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
